memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Sequences a single read or write transaction between the datapath's MAR/MDR pair and a synchronous RAM that has a ready/acknowledge handshake.
- Sits directly upstream of the memory data register. It produces the Mdatain word, the Read mux select, and the MDR load enable.
- It consumes the MAR address and the MDR output (Q) as write data.
- The control unit issues one-cycle request pulses and waits for done.

Parameters:
- ADDR_W, 9: RAM word-address width; taken from mar_addr[ADDR_W-1:0].
- DATA_W, 32: data width on all data ports.
- TIMEOUT, 16: cycles to wait for mem_ready before abort (used only with MEMC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous active-low reset.
- read_req  in  1  one-cycle pulse from the control unit: start a read.
- write_req  in  1  one-cycle pulse from the control unit: start a write.
- mar_addr  in  32  MAR output.
- mdr_q  in  DATA_W  MDR output (Q); the write data.
- mem_rdata  in  DATA_W  RAM read data; valid when mem_ready=1 during a read.
- mem_ready  in  1  RAM acknowledge.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rd  out  1  RAM read strobe.
- mem_wr  out  1  RAM write strobe.
- Mdatain  out  DATA_W  captured read word, feeding the MDR input mux.
- mdr_read  out  1  MDR mux select (1 = Mdatain).
- mdr_en  out  1  MDR load enable.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

Behaviour:
- All outputs are registered.
- Reset (clr=0, asynchronous, immediate): state=IDLE. Every output is 0, including mem_addr, mem_wdata, Mdatain, the strobes, busy, done and err. The timeout counter is 0.
- States: IDLE, RD_REQ, RD_LOAD, WR_REQ, DONE.
- IDLE:
  - busy=0.
  - read_req=1: latch mem_addr <= mar_addr[ADDR_W-1:0], go to RD_REQ, and set mem_rd=1 and busy=1 on that same edge.
  - write_req=1 (read_req=0): latch mem_addr, latch mem_wdata <= mdr_q, go to WR_REQ, and set mem_wr=1 and busy=1.
  - Both requests high: read wins; the write is dropped, not queued.
  - mem_ready in IDLE is ignored.
- RD_REQ:
  - mem_rd is held at 1 until mem_ready=1 is sampled.
  - On that edge: Mdatain <= mem_rdata, mem_rd <= 0, mdr_read <= 1, mdr_en <= 1, go to RD_LOAD.
- RD_LOAD:
  - mdr_read and mdr_en are high for exactly this one cycle, so the MDR loads Mdatain on the next edge.
  - Next edge: both drop to 0, go to DONE.
- WR_REQ:
  - mem_wr is held at 1 until mem_ready=1 is sampled.
  - On that edge: mem_wr <= 0, go to DONE.
- DONE:
  - done=1 and busy=1 for one cycle.
  - Next edge: go to IDLE with busy=0 and done=0.
- Mdatain holds its last captured value until the next read completes; it is not cleared in DONE/IDLE.
- mem_addr and mem_wdata are stable for the whole transaction. A mar_addr or mdr_q change after the request is not observed.
- Requests arriving while busy=1, including the DONE cycle, are ignored.
- Latency, with the request sampled at edge E and mem_ready already high at edge E+1:
  - Read: mdr_en high after E+1, done high after E+2, busy low after E+3. Minimum read is 3 cycles.
  - Write: done high after E+1, busy low after E+2. Minimum write is 2 cycles.
- Reset mid-transaction: the strobes drop asynchronously and the transaction is abandoned. No done or err pulse is produced.

Optional Feature:
- Macro MEMC_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in RD_REQ/WR_REQ while mem_ready=0 and clears on state entry.
  - When it reaches TIMEOUT-1 without mem_ready, the next edge drops the strobe and goes to DONE with done=1 and err=1 (one cycle each).
  - mdr_en is never asserted and Mdatain is unchanged.
  - mem_ready in the same cycle as the terminal count takes priority: normal completion, no err.
- Not defined: no counter; the controller waits for mem_ready indefinitely and err is tied to 0.

Test Plan:
- Reset: hold clr=0 with random inputs -> all outputs 0. Release clr -> IDLE, busy=0.
- Read, zero wait: mar_addr=0x0000_0105, pulse read_req, mem_ready=1, mem_rdata=0xDEAD_BEEF ->
  - mem_addr=0x105 and mem_rd=1 for 1 cycle.
  - Next cycle: Mdatain=0xDEAD_BEEF with mdr_read=mdr_en=1 for one cycle.
  - Then done=1 for one cycle.
- Write with 3 wait cycles: mdr_q=0x1234_5678, mar_addr=0x7, pulse write_req, mem_ready low for 3 cycles then high -> mem_wr=1 for 4 cycles, mem_wdata=0x1234_5678, then done for one cycle, no mdr_en.
- Collision and busy: read_req and write_req in the same cycle -> read only. A write_req pulse while busy -> ignored, mem_wr never asserts.
- Reset mid-read: clr=0 while in RD_REQ -> mem_rd=0 immediately, no done. The next read after release works normally.
- With MEMC_TIMEOUT_EN and TIMEOUT=16: read with mem_ready held at 0 -> mem_rd high for 16 cycles, then done=err=1 for one cycle, Mdatain unchanged, mdr_en never asserted.

Source files
------------

// File: rtl/memory_controller.sv
// memory_controller
// -----------------------------------------------------------------------------
// Sequences one read or one write between the datapath MAR/MDR pair and a
// synchronous RAM with a ready/acknowledge handshake. The control unit issues
// one-cycle read_req / write_req pulses and waits for the done pulse.
//
// Optional feature: define MEMC_TIMEOUT_EN to abort a transaction when
// mem_ready does not arrive within TIMEOUT cycles (done and err pulse together).
// Without it the controller waits for mem_ready indefinitely and err stays 0.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   clr        in   asynchronous active-low reset
//   read_req   in   one-cycle pulse: start a read
//   write_req  in   one-cycle pulse: start a write (a simultaneous read wins)
//   mar_addr   in   MAR output; low ADDR_W bits are the RAM word address
//   mdr_q      in   MDR output, used as write data
//   mem_rdata  in   RAM read data, valid with mem_ready during a read
//   mem_ready  in   RAM acknowledge
//   mem_addr   out  registered RAM address
//   mem_wdata  out  registered RAM write data
//   mem_rd     out  RAM read strobe
//   mem_wr     out  RAM write strobe
//   Mdatain    out  captured read word feeding the MDR input mux
//   mdr_read   out  MDR mux select (1 = Mdatain)
//   mdr_en     out  MDR load enable
//   busy       out  transaction in progress
//   done       out  one-cycle completion pulse
//   err        out  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module memory_controller #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [31:0]       mar_addr,
    input  logic [DATA_W-1:0] mdr_q,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mdr_read,
    output logic              mdr_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_LOAD = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [DATA_W-1:0]   r_mdatain;
    logic                r_mdr_read;
    logic                r_mdr_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // Upper MAR bits address nothing in this RAM.
    logic w_unused_mar_hi;
    assign w_unused_mar_hi = ^mar_addr[31:ADDR_W];

`ifdef MEMC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             w_terminal;
    // Terminal count: this is the last cycle the strobe may wait for mem_ready.
    assign w_terminal = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mdatain   <= {DATA_W{1'b0}};
            r_mdr_read  <= 1'b0;
            r_mdr_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef MEMC_TIMEOUT_EN
            r_cnt       <= {CNT_W{1'b0}};
`endif
        end else begin
            // done/err are pulses: only the transition into DONE raises them.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
`ifdef MEMC_TIMEOUT_EN
                    r_cnt  <= {CNT_W{1'b0}};
`endif
                    if (read_req) begin
                        // Read has priority; a simultaneous write is dropped.
                        r_mem_addr <= mar_addr[ADDR_W-1:0];
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RD_REQ;
                    end else if (write_req) begin
                        r_mem_addr  <= mar_addr[ADDR_W-1:0];
                        r_mem_wdata <= mdr_q;
                        r_mem_wr    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_WR_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (mem_ready) begin
                        r_mdatain  <= mem_rdata;
                        r_mem_rd   <= 1'b0;
                        r_mdr_read <= 1'b1;
                        r_mdr_en   <= 1'b1;
                        r_state    <= S_RD_LOAD;
`ifdef MEMC_TIMEOUT_EN
                    end else if (w_terminal) begin
                        // Abort: no MDR load, Mdatain keeps its old value.
                        r_mem_rd <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`else
                    end else begin
                        r_mem_rd <= 1'b1;
`endif
                    end
                end
                S_RD_LOAD: begin
                    // MDR captures Mdatain on this edge; select/enable drop now.
                    r_mdr_read <= 1'b0;
                    r_mdr_en   <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_WR_REQ: begin
                    if (mem_ready) begin
                        r_mem_wr <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
`ifdef MEMC_TIMEOUT_EN
                    end else if (w_terminal) begin
                        r_mem_wr <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`else
                    end else begin
                        r_mem_wr <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    // Requests seen in this cycle are deliberately ignored.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_rd   <= 1'b0;
                    r_mem_wr   <= 1'b0;
                    r_mdr_read <= 1'b0;
                    r_mdr_en   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign Mdatain   = r_mdatain;
    assign mdr_read  = r_mdr_read;
    assign mdr_en    = r_mdr_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller (default build, no timeout feature).
// Stimulus tasks push the expected transaction record; an independent monitor
// on the falling edge accumulates what the DUT does and compares on done.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        clr;
    logic        read_req, write_req;
    logic [31:0] mar_addr, mdr_q, mem_rdata;
    logic        mem_ready;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, Mdatain;
    logic        mem_rd, mem_wr, mdr_read, mdr_en, busy, done, err;

    always #5 clk = ~clk;

    memory_controller #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .clr(clr), .read_req(read_req), .write_req(write_req),
        .mar_addr(mar_addr), .mdr_q(mdr_q), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .Mdatain(Mdatain),
        .mdr_read(mdr_read), .mdr_en(mdr_en), .busy(busy), .done(done),
        .err(err)
    );

    typedef struct {
        bit          is_rd;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mdatain;
        int          strobe_cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rd  = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    int          m_rd_cnt, m_wr_cnt, m_en_cnt;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_mdat;
    bit          m_bad, m_prev_en, m_prev_wr, m_prev_done, m_spur;
    exp_t        m_e;

    always @(negedge clk) begin
        if (clr !== 1'b1) begin
            sb.delete();
            m_rd_cnt = 0; m_wr_cnt = 0; m_en_cnt = 0;
            m_bad = 0; m_prev_en = 0; m_prev_wr = 0; m_prev_done = 0; m_spur = 0;
        end else begin
            if (m_prev_done) check("post_done_idle", {busy, done}, 2'b00);
            if (mem_rd || mem_wr) begin
                if (sb.size() == 0 && !m_spur) begin
                    m_spur = 1;
                    check("spurious_strobe", {mem_rd, mem_wr}, 2'b00);
                end
                if (m_rd_cnt + m_wr_cnt == 0) begin
                    m_addr  = mem_addr;
                    m_wdata = mem_wdata;
                end else if (mem_addr !== m_addr || mem_wdata !== m_wdata) begin
                    m_bad = 1;
                end
                if (!busy) m_bad = 1;
            end
            if (mem_rd) m_rd_cnt++;
            if (mem_wr) m_wr_cnt++;
            if (mem_rd && mem_wr) m_bad = 1;
            if (mdr_en) begin
                m_en_cnt++;
                m_mdat = Mdatain;
            end
            if (mdr_read !== mdr_en) m_bad = 1;
            if (err !== 1'b0) m_bad = 1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    m_e = sb.pop_front();
                    check("addr", m_addr, m_e.addr);
                    check("mdatain", Mdatain, m_e.mdatain);
                    check("busy_at_done", busy, 1'b1);
                    check("protocol", m_bad, 1'b0);
                    if (m_e.is_rd) begin
                        check("rd_cycles", m_rd_cnt, m_e.strobe_cycles);
                        check("rd_no_wr", m_wr_cnt, 0);
                        check("rd_mdr_en_cycles", m_en_cnt, 1);
                        check("rd_load_word", m_mdat, m_e.mdatain);
                        check("rd_done_latency", m_prev_en, 1'b1);
                    end else begin
                        check("wr_cycles", m_wr_cnt, m_e.strobe_cycles);
                        check("wr_no_rd", m_rd_cnt, 0);
                        check("wr_no_mdr_en", m_en_cnt, 0);
                        check("wdata", m_wdata, m_e.wdata);
                        check("wr_done_latency", m_prev_wr, 1'b1);
                    end
                end
                m_rd_cnt = 0; m_wr_cnt = 0; m_en_cnt = 0; m_bad = 0; m_spur = 0;
            end
            m_prev_en   = mdr_en;
            m_prev_wr   = mem_wr;
            m_prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        for (int i = 0; i < 8 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("idle_reached", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int waits,
                           input bit collide, input bit poke);
        exp_t e;
        e.is_rd = 1; e.addr = a[8:0]; e.wdata = 32'h0; e.mdatain = d;
        e.strobe_cycles = waits + 1;
        sb.push_back(e);
        mar_addr = a; read_req = 1'b1; write_req = collide;
        mdr_q = 32'hBAD0_0BAD; mem_ready = 1'b0; mem_rdata = $urandom;
        @(posedge clk); #1;
        read_req = 1'b0; write_req = 1'b0; mar_addr = ~a; mdr_q = $urandom;
        for (int i = 0; i < waits; i++) begin
            if (poke && i == 0) write_req = 1'b1;
            @(posedge clk); #1;
            write_req = 1'b0;
        end
        mem_ready = 1'b1; mem_rdata = d;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(posedge clk); #1;
        if (poke) begin
            read_req = 1'b1; write_req = 1'b1;
        end
        @(posedge clk); #1;
        read_req = 1'b0; write_req = 1'b0;
        last_rd = d;
        wait_idle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int waits);
        exp_t e;
        e.is_rd = 0; e.addr = a[8:0]; e.wdata = d; e.mdatain = last_rd;
        e.strobe_cycles = waits + 1;
        sb.push_back(e);
        mar_addr = a; mdr_q = d; write_req = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        write_req = 1'b0; mar_addr = ~a; mdr_q = ~d;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        wait_idle();
    endtask

    initial begin
        clr = 1'b0; read_req = 1'b0; write_req = 1'b0; mem_ready = 1'b0;
        mar_addr = 32'h0; mdr_q = 32'h0; mem_rdata = 32'h0;
        // Reset held with random inputs: every output must stay 0.
        for (int i = 0; i < 4; i++) begin
            read_req = 1'($urandom); write_req = 1'($urandom); mem_ready = 1'($urandom);
            mar_addr = $urandom; mdr_q = $urandom; mem_rdata = $urandom;
            @(negedge clk);
            check("reset_addr", mem_addr, 9'h0);
            check("reset_wdata", mem_wdata, 32'h0);
            check("reset_mdatain", Mdatain, 32'h0);
            check("reset_ctrl", {mem_rd, mem_wr, mdr_read, mdr_en, busy, done, err}, 7'h0);
        end
        read_req = 1'b0; write_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        check("release_idle", {busy, mem_rd, mem_wr}, 3'b000);
        @(posedge clk); #1;

        do_read(32'h0000_0105, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        do_write(32'h0000_0007, 32'h1234_5678, 3);
        do_write(32'hFFFF_FFFF, 32'hA5A5_5A5A, 0);
        do_read(32'h0000_0042, 32'h0F0F_F0F0, 2, 1'b1, 1'b1);
        do_read(32'h8000_0000, 32'h0000_0001, 5, 1'b0, 1'b1);

        // Reset in the middle of a read: strobe drops at once, no done.
        begin
            exp_t e;
            e.is_rd = 1; e.addr = 9'h033; e.wdata = 32'h0; e.mdatain = 32'h0;
            e.strobe_cycles = 1;
            sb.push_back(e);
        end
        mar_addr = 32'h33; read_req = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        read_req = 1'b0;
        @(posedge clk); #1;
        check("mid_read_strobe", mem_rd, 1'b1);
        clr = 1'b0;
        #1;
        check("abort_rd_async", {mem_rd, busy, done}, 3'b000);
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
        @(posedge clk); #1;
        clr = 1'b1;
        last_rd = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_abort_quiet", {done, busy, mem_rd}, 3'b000);
        end
        @(posedge clk); #1;

        do_read(32'h0000_0033, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
        do_write(32'h0000_0100, 32'h5555_AAAA, 1);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
